// File: rtl/tenkey_scan_if.sv
// Keypad matrix bundle between the scanner and the switch matrix / lock side.
//   row_n  : matrix row returns, active-low (matrix -> scanner)
//   col_n  : column drive, active-low, one-cold (scanner -> matrix)
//   tenkey : one-hot debounced digit (scanner -> lock)
//   close  : debounced '*' level (scanner -> lock)
interface tenkey_scan_if;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [9:0] tenkey;
  logic       close;

  // Matrix / environment side: drives rows, observes columns and results.
  modport master (output row_n, input col_n, tenkey, close);
  // Scanner side.
  modport slave (input row_n, output col_n, tenkey, close);
endinterface

// File: rtl/tenkey_scan.sv
// 4x3 keypad scanner: drives one column low at a time, synchronises the row
// returns, builds a per-frame key result and debounces it into one-hot digit
// lines plus a close level for the '*' key.
// Ports:
//   ck    : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : tenkey_scan_if.slave (row_n in; col_n, tenkey, close out)
module tenkey_scan #(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic          ck,
  input  logic          reset,
  tenkey_scan_if.slave  bus
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned DEB_W  = 4;
  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_STAR = CODE_W'(10);
  localparam logic [CODE_W-1:0] CODE_HASH = CODE_W'(11);
  localparam logic [CODE_W-1:0] CODE_NONE = CODE_W'(15);
  localparam logic [DIV_W-1:0]  TC_VAL    = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_FRAMES);

  typedef enum logic [1:0] {COL0 = 2'd0, COL1 = 2'd1, COL2 = 2'd2} col_e;

  col_e              col_q, col_nxt;
  logic [2:0]        col_n_q, col_n_d;
  logic [3:0]        row_s1, row_s2;
  logic [DIV_W-1:0]  presc;
  logic              tc;
  logic [1:0]        hit_cnt, hit_cnt_nxt;
  logic [CODE_W-1:0] hit_code, hit_code_nxt;
  logic [CODE_W-1:0] cand, cand_nxt;
  logic [DEB_W-1:0]  stable, stable_nxt;
  logic [9:0]        tenkey_q, tenkey_nxt;
  logic              close_q, close_nxt;

  // Key code at a matrix position; row 3 holds '*', 0 and '#'.
  function automatic logic [CODE_W-1:0] key_code(input logic [1:0] row,
                                                 input logic [1:0] col);
    if (row == 2'd3) begin
      case (col)
        2'd0:    key_code = CODE_STAR;
        2'd1:    key_code = CODE_W'(0);
        default: key_code = CODE_HASH;
      endcase
    end else begin
      key_code = CODE_W'(row) * CODE_W'(3) + CODE_W'(col) + CODE_W'(1);
    end
  endfunction

  assign tc = (presc == TC_VAL);

  // Column state register, synchroniser and prescaler.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      col_q   <= COL0;
      col_n_q <= 3'b110;
      row_s1  <= 4'b1111;
      row_s2  <= 4'b1111;
      presc   <= '0;
    end else begin
      col_q   <= col_nxt;
      col_n_q <= col_n_d;
      row_s1  <= bus.row_n;
      row_s2  <= row_s1;
      presc   <= tc ? '0 : presc + DIV_W'(1);
    end
  end

  // Column advance on terminal count.
  always_comb begin
    col_nxt = col_q;
    if (tc) begin
      case (col_q)
        COL0:    col_nxt = COL1;
        COL1:    col_nxt = COL2;
        default: col_nxt = COL0;
      endcase
    end
  end

  // Column drive for the state being entered, so col_n stays registered.
  always_comb begin
    col_n_d = 3'b110;
    case (col_nxt)
      COL1:    col_n_d = 3'b101;
      COL2:    col_n_d = 3'b011;
      default: col_n_d = 3'b110;
    endcase
  end

  // Frame accumulation, frame result and debounce.
  always_comb begin
    logic [2:0]        col_hits;
    logic [CODE_W-1:0] col_code;
    logic [1:0]        base_cnt;
    logic [CODE_W-1:0] base_code;
    logic [2:0]        sum;
    logic [CODE_W-1:0] result;

    col_hits     = '0;
    col_code     = CODE_NONE;
    hit_cnt_nxt  = hit_cnt;
    hit_code_nxt = hit_code;
    cand_nxt     = cand;
    stable_nxt   = stable;
    tenkey_nxt   = tenkey_q;
    close_nxt    = close_q;
    result       = CODE_NONE;

    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_code(2'(r), 2'(col_q));
      end
    end

    // Column 0 starts a fresh frame.
    base_cnt  = (col_q == COL0) ? 2'd0 : hit_cnt;
    base_code = (col_q == COL0) ? CODE_NONE : hit_code;
    sum       = 3'(base_cnt) + col_hits;

    if (tc) begin
      hit_cnt_nxt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      hit_code_nxt = (col_hits != 3'd0) ? col_code : base_code;

      if (col_q == COL2) begin
        result = (hit_cnt_nxt == 2'd1) ? hit_code_nxt : CODE_NONE;
        if (result == cand) begin
          stable_nxt = (stable >= DEB_MAX) ? DEB_MAX : stable + DEB_W'(1);
        end else begin
          cand_nxt   = result;
          stable_nxt = DEB_W'(1);
        end
        if (stable_nxt == DEB_MAX) begin
          tenkey_nxt = (cand_nxt <= CODE_W'(9)) ? (10'(1) << cand_nxt) : '0;
          close_nxt  = (cand_nxt == CODE_STAR);
        end
      end
    end
  end

  // Accumulator, debounce and output registers.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      hit_code <= CODE_NONE;
      cand     <= CODE_NONE;
      stable   <= '0;
      tenkey_q <= '0;
      close_q  <= 1'b0;
    end else begin
      hit_cnt  <= hit_cnt_nxt;
      hit_code <= hit_code_nxt;
      cand     <= cand_nxt;
      stable   <= stable_nxt;
      tenkey_q <= tenkey_nxt;
      close_q  <= close_nxt;
    end
  end

  assign bus.col_n  = col_n_q;
  assign bus.tenkey = tenkey_q;
  assign bus.close  = close_q;

endmodule
